// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared definitions for the convolution processor datapath.
//               ALU opcodes and control-word field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  // ALU opcodes, control_signal[ALU_OP_HI:ALU_OP_LO]
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_NORM = 4'b0100;
  localparam logic [3:0] OP_PASS = 4'b0101;
  localparam logic [3:0] OP_LOAD = 4'b0110;
  localparam logic [3:0] OP_INC  = 4'b0111;
  localparam logic [3:0] OP_CLR  = 4'b1001;

  // Control-word field positions
  localparam int NEXT_HI    = 37;
  localparam int NEXT_LO    = 32;
  localparam int ALU_OP_HI  = 31;
  localparam int ALU_OP_LO  = 28;
  localparam int BUS_SEL_HI = 4;
  localparam int BUS_SEL_LO = 0;

  // Register-enable bit indices; AC is the only one consumed by the ALU block
  localparam int REG_EN_LO  = 5;
  localparam int AC_WE_BIT  = 9;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU for the accumulator datapath.
//               Computes the next AC candidate and flag side effects.
// Ports       : i_op      - ALU opcode
//               i_ac      - current accumulator value
//               i_bus     - bus operand
//               o_r       - result (equals i_ac for NOP/PASS/reserved)
//               o_ovf_set - op overflowed / saturated
//               o_clr     - op clears the sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import conv_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NORM_SHIFT = 4,
  parameter int PIX_MAX    = 255
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_ac,
  input  logic [DATA_W-1:0] i_bus,
  output logic [DATA_W-1:0] o_r,
  output logic              o_ovf_set,
  output logic              o_clr
);

  localparam logic [DATA_W-1:0] c_PIX_MAX = DATA_W'(PIX_MAX);

  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W:0]     w_inc;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_shr;

  // The extra top bit is carry for sum/inc and borrow for diff
  assign w_sum  = {1'b0, i_ac} + {1'b0, i_bus};
  assign w_diff = {1'b0, i_ac} - {1'b0, i_bus};
  assign w_inc  = {1'b0, i_ac} + (DATA_W+1)'(1);
  assign w_prod = {{DATA_W{1'b0}}, i_ac} * {{DATA_W{1'b0}}, i_bus};
  assign w_shr  = i_ac >> NORM_SHIFT;

  always_comb begin
    o_r       = i_ac;
    o_ovf_set = 1'b0;
    o_clr     = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_r       = w_sum[DATA_W-1:0];
        o_ovf_set = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_r       = w_diff[DATA_W-1:0];
        o_ovf_set = w_diff[DATA_W];
      end
      OP_MUL: begin
        o_r       = w_prod[DATA_W-1:0];
        o_ovf_set = |w_prod[2*DATA_W-1:DATA_W];
      end
      OP_NORM: begin
        if (w_shr > c_PIX_MAX) begin
          o_r       = c_PIX_MAX;
          o_ovf_set = 1'b1;
        end else begin
          o_r       = w_shr;
        end
      end
      OP_LOAD: o_r = i_bus;
      OP_INC: begin
        o_r       = w_inc[DATA_W-1:0];
        o_ovf_set = w_inc[DATA_W];
      end
      OP_CLR: begin
        o_r   = '0;
        o_clr = 1'b1;
      end
      default: ; // NOP, PASS and reserved codes hold AC
    endcase
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : alu_accumulator
// Description : Accumulator register, zero flag and sticky overflow flag
//               around alu_core, driven by the microcoded control word.
// Ports       : clk            - clock
//               reset_n        - synchronous active-low reset
//               control_signal - 38-bit control word (op [31:28], AC WE [9])
//               bus_in         - bus operand
//               ac             - registered accumulator
//               ac_bus_drive   - AC is the bus source (PASS op)
//               Z_flag         - registered AC == 0
//               ovf            - sticky overflow, cleared by CLR or reset
// Revision    : 1.0 - initial release
// ============================================================================
module alu_accumulator
  import conv_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NORM_SHIFT = 4,
  parameter int PIX_MAX    = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       control_signal,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] ac,
  output logic              ac_bus_drive,
  output logic              Z_flag,
  output logic              ovf
);

  logic [3:0]        w_op;
  logic              w_we;
  logic [DATA_W-1:0] w_r;
  logic              w_ovf_set;
  logic              w_clr;
  logic [DATA_W-1:0] r_ac;
  logic              r_z;
  logic              r_ovf;
  logic              w_unused_ctrl;

  assign w_op = control_signal[ALU_OP_HI:ALU_OP_LO];
  assign w_we = control_signal[AC_WE_BIT];

  // Fields owned by other datapath blocks
  assign w_unused_ctrl = ^{control_signal[NEXT_HI:NEXT_LO],
                           control_signal[ALU_OP_LO-1:AC_WE_BIT+1],
                           control_signal[AC_WE_BIT-1:BUS_SEL_LO]};

  alu_core #(
    .DATA_W     (DATA_W),
    .NORM_SHIFT (NORM_SHIFT),
    .PIX_MAX    (PIX_MAX)
  ) u_alu_core (
    .i_op      (w_op),
    .i_ac      (r_ac),
    .i_bus     (bus_in),
    .o_r       (w_r),
    .o_ovf_set (w_ovf_set),
    .o_clr     (w_clr)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ac  <= '0;
      r_z   <= 1'b1;
      r_ovf <= 1'b0;
    end else if (w_we) begin
      r_ac  <= w_r;
      r_z   <= (w_r == '0);
      // CLR wins over any set condition in the same cycle
      r_ovf <= w_clr ? 1'b0 : (r_ovf | w_ovf_set);
    end
  end

  assign ac           = r_ac;
  assign Z_flag       = r_z;
  assign ovf          = r_ovf;
  assign ac_bus_drive = (w_op == OP_PASS);

endmodule : alu_accumulator
`default_nettype wire
